tank_sprite_rom_arbiter: RTL

Round-robin arbiter sharing one synchronous 32x32 sprite index ROM (1024 x 4-bit, one-cycle read latency) among several sprite requesters (player tanks, enemy tanks, shells). Sits between the per-sprite draw logic and the single ROM instance, and returns each read tagged with the requester ID. The palette lookup stays downstream. Lets several on-screen objects reuse one ROM instead of instantiating a ROM per sprite.

---
 rtl/tank_sprite_pkg.sv | 17 +
 rtl/tank_sprite_rom_arbiter_rr_pick.sv | 40 ++++
 rtl/tank_sprite_rom_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/tank_sprite_pkg.sv
// Shared sprite ROM geometry and palette constants for the tank sprite pipeline.
// 32x32 sprites stored as 4-bit palette indices, one word per pixel.
package tank_sprite_pkg;

    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_DATA_W = 4;

    typedef logic [SPRITE_DATA_W-1:0] sprite_idx_t;
    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;

    localparam sprite_idx_t TRANSPARENT_IDX = 4'h0;

    function automatic logic idx_is_opaque(input sprite_idx_t v);
        return v != TRANSPARENT_IDX;
    endfunction

endpackage

// File: rtl/tank_sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr upward with wrap, first asserted req wins.
// Produces a one-hot grant, its binary id and an any-grant flag.
module rr_pick
    import tank_sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the requester closest to ptr is written last.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any     = 1'b0;
        idx_sum = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx_sum >= (ID_W + 1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = idx_sum[ID_W-1:0];
            if (req[idx]) begin
                gnt    = NUM_REQ'(1) << idx;
                gnt_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tank_sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite index ROM among several sprite requesters.
// Responses come back two cycles after the grant, tagged with the requester id.
module tank_sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = tank_sprite_pkg::SPRITE_ADDR_W,
    parameter int DATA_W  = tank_sprite_pkg::SPRITE_DATA_W,
    parameter logic [DATA_W-1:0] TRANSPARENT_IDX = DATA_W'(tank_sprite_pkg::TRANSPARENT_IDX),
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_opaque
);

    import tank_sprite_pkg::*;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] req_live;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;

    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    ptr_next;
    logic [ADDR_W-1:0]  addr_hold_reg;
    logic               s1_valid_reg;
    logic [ID_W-1:0]    s1_id_reg;
    logic               rsp_valid_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [DATA_W-1:0]  rsp_data_reg;
    logic               rsp_opaque_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Requests are masked during reset so no grant escapes while reset_n is low.
    assign req_live = reset_n ? req : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_live),
        .ptr    (ptr_reg),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_any) begin
            if (gnt_id == ID_W'(NUM_REQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = gnt_id + ID_W'(1);
            end
        end
    end

    // Idle cycles keep the ROM pointed at the last granted address.
    assign rom_address = gnt_any ? addr_arr[gnt_id] : addr_hold_reg;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            ptr_reg        <= '0;
            addr_hold_reg  <= '0;
            s1_valid_reg   <= 1'b0;
            s1_id_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_data_reg   <= '0;
            rsp_opaque_reg <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            s1_valid_reg <= gnt_any;
            if (gnt_any) begin
                addr_hold_reg <= rom_address;
                s1_id_reg     <= gnt_id;
            end
            rsp_valid_reg <= s1_valid_reg;
            // rom_q belongs to the stage-1 read; capture only when that read was real.
            if (s1_valid_reg) begin
                rsp_id_reg     <= s1_id_reg;
                rsp_data_reg   <= rom_q;
                rsp_opaque_reg <= (rom_q != TRANSPARENT_IDX);
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_opaque = rsp_opaque_reg;

endmodule
